// File: rtl/r_rob_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : r_rob_pkg                                                    |
// | Description : Shared constants and types for the R-channel reorder path.   |
// |               Holds the default configuration, the {row,col} UID width     |
// |               derivation, the UID type and the R payload record.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package r_rob_pkg;

  // Default configuration of the reorder path.
  localparam int DEF_ID_WIDTH        = 4;
  localparam int DEF_DATA_WIDTH      = 64;
  localparam int DEF_RESP_WIDTH      = 2;
  localparam int DEF_TAG_WIDTH       = 4;
  localparam int DEF_MAX_OUTSTANDING = 16;
  localparam int DEF_NUM_ROWS        = DEF_MAX_OUTSTANDING;
  localparam int DEF_NUM_COLS        = DEF_MAX_OUTSTANDING;

  // A UID is {row,col}: the row is the ORIGINAL-ID row, the column is the
  // position of the response inside that row.
  localparam int ROW_W = $clog2(DEF_NUM_ROWS);
  localparam int COL_W = $clog2(DEF_NUM_COLS);
  localparam int UID_W = ROW_W + COL_W;

  typedef logic [UID_W-1:0] uid_t;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_RESP_WIDTH-1:0] resp;
    logic                      last;
    logic [DEF_TAG_WIDTH-1:0]  tagid;
  } r_payload_t;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/r_wm_free_slot_finder.sv
// +----------------------------------------------------------------------------+
// | Module      : r_wm_free_slot_finder                                        |
// | Description : Lowest-index-zero priority encoder. Returns the index of the |
// |               lowest entry whose valid bit is clear and flags whether any  |
// |               such entry exists.                                           |
// | Ports       : valid    in  DEPTH  per-entry occupied bits                  |
// |               free_idx out IDX_W  lowest free index (0 when none free)     |
// |               any_free out 1      at least one entry is free               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module r_wm_free_slot_finder #(
  parameter int DEPTH = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] valid,
  output logic [IDX_W-1:0] free_idx,
  output logic             any_free
);

  // Scanning from the top down lets the lowest free index win the last
  // assignment.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/r_response_waiting_memory.sv
// +----------------------------------------------------------------------------+
// | Module      : r_response_waiting_memory                                    |
// | Description : Fully associative, UID-addressed holding store for read      |
// |               responses that arrived ahead of their turn in their          |
// |               ORIGINAL-ID row. Writes land in the lowest free entry one    |
// |               cycle later; releases look up the UID combinationally and    |
// |               free the matching entry at the clock edge.                   |
// | Ports       : clk, rst (async, active-high)                                |
// |               wr_en/wr_uid/wr_id/wr_data/wr_resp/wr_last/wr_tagid  store    |
// |               rel_en/rel_uid                                  release req  |
// |               rel_hit/rel_id/rel_data/rel_resp/rel_last/rel_tagid release  |
// |               full, empty, count, peak_count                 occupancy     |
// |               err_dup, err_miss, err_overflow                sticky errors |
// | Config      : R_WM_ERR_CHECK_EN - enables duplicate-UID rejection and the  |
// |               sticky error flags; when undefined the flags read 0.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module r_response_waiting_memory
  import r_rob_pkg::*;
#(
  parameter int ID_WIDTH        = DEF_ID_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int RESP_WIDTH      = DEF_RESP_WIDTH,
  parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int NUM_ROWS        = MAX_OUTSTANDING,
  parameter int NUM_COLS        = MAX_OUTSTANDING,
  parameter int ROW_W_P         = $clog2(NUM_ROWS),
  parameter int COL_W_P         = $clog2(NUM_COLS),
  parameter int UID_W_P         = ROW_W_P + COL_W_P,
  parameter int CNT_W           = occ_width(MAX_OUTSTANDING)
) (
  input  logic                  clk,
  input  logic                  rst,
  // store side
  input  logic                  wr_en,
  input  logic [UID_W_P-1:0]    wr_uid,
  input  logic [ID_WIDTH-1:0]   wr_id,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [RESP_WIDTH-1:0] wr_resp,
  input  logic                  wr_last,
  input  logic [TAG_WIDTH-1:0]  wr_tagid,
  // release side
  input  logic                  rel_en,
  input  logic [UID_W_P-1:0]    rel_uid,
  output logic                  rel_hit,
  output logic [ID_WIDTH-1:0]   rel_id,
  output logic [DATA_WIDTH-1:0] rel_data,
  output logic [RESP_WIDTH-1:0] rel_resp,
  output logic                  rel_last,
  output logic [TAG_WIDTH-1:0]  rel_tagid,
  // occupancy and status
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      peak_count,
  output logic                  err_dup,
  output logic                  err_miss,
  output logic                  err_overflow
);

  localparam int DEPTH = MAX_OUTSTANDING;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;
    logic [TAG_WIDTH-1:0]  tagid;
  } payload_t;

  // Storage. Only the valid bits need a reset; uid/payload are qualified by
  // valid everywhere they are read.
  logic [DEPTH-1:0]   r_valid;
  logic [UID_W_P-1:0] r_uid     [DEPTH];
  payload_t           r_payload [DEPTH];

  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_peak;
  logic               r_full;
  logic               r_empty;

  logic [DEPTH-1:0]   w_match;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_any_match;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_any_free;
  logic               w_dup;
  logic               w_wr_accept;
  logic [CNT_W-1:0]   w_count_next;
  payload_t           w_wr_payload;
  payload_t           w_rel_payload;

  // --------------------------------------------------------------------------
  // Release lookup: compare rel_uid against every valid entry.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign w_match[g] = rel_en && r_valid[g] && (r_uid[g] == rel_uid);
  end

  // With duplicates allowed, more than one entry can match; the lowest index
  // wins so release order follows write order into the free-slot search.
  always_comb begin
    w_hit_idx   = '0;
    w_any_match = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit_idx   = IDX_W'(i);
        w_any_match = 1'b1;
      end
    end
  end

  assign rel_hit       = w_any_match;
  assign w_rel_payload = w_any_match ? r_payload[w_hit_idx] : '0;
  assign rel_id        = w_rel_payload.id;
  assign rel_data      = w_rel_payload.data;
  assign rel_resp      = w_rel_payload.resp;
  assign rel_last      = w_rel_payload.last;
  assign rel_tagid     = w_rel_payload.tagid;

  // --------------------------------------------------------------------------
  // Write side. The free-slot search sees only pre-edge valid bits, so a
  // slot being released in this cycle is never reused in the same cycle.
  // --------------------------------------------------------------------------
  r_wm_free_slot_finder #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_free_slot_finder (
    .valid    (r_valid),
    .free_idx (w_free_idx),
    .any_free (w_any_free)
  );

`ifdef R_WM_ERR_CHECK_EN
  // Any valid entry counts, including one being released this cycle.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_uid[i] == wr_uid)) begin
        w_dup = 1'b1;
      end
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  assign w_wr_accept  = wr_en && !r_full && w_any_free && !w_dup;

  assign w_wr_payload = '{id:    wr_id,
                          data:  wr_data,
                          resp:  wr_resp,
                          last:  wr_last,
                          tagid: wr_tagid};

  assign w_count_next = r_count + CNT_W'(w_wr_accept) - CNT_W'(w_any_match);

  // --------------------------------------------------------------------------
  // State update. A write and a release never target the same entry: the
  // write goes to an invalid slot, the release clears a valid one.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
      r_peak  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_accept) begin
        r_valid[w_free_idx] <= 1'b1;
      end
      if (w_any_match) begin
        r_valid[w_hit_idx] <= 1'b0;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == C_DEPTH);
      r_empty <= (w_count_next == '0);
      if (w_count_next > r_peak) begin
        r_peak <= w_count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_uid[w_free_idx]     <= wr_uid;
      r_payload[w_free_idx] <= w_wr_payload;
    end
  end

  assign count      = r_count;
  assign peak_count = r_peak;
  assign full       = r_full;
  assign empty      = r_empty;

  // --------------------------------------------------------------------------
  // Sticky protocol error flags.
  // --------------------------------------------------------------------------
`ifdef R_WM_ERR_CHECK_EN
  logic r_err_dup;
  logic r_err_miss;
  logic r_err_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_dup      <= 1'b0;
      r_err_miss     <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (wr_en && w_dup) begin
        r_err_dup <= 1'b1;
      end
      if (rel_en && !w_any_match) begin
        r_err_miss <= 1'b1;
      end
      if (wr_en && r_full) begin
        r_err_overflow <= 1'b1;
      end
    end
  end

  assign err_dup      = r_err_dup;
  assign err_miss     = r_err_miss;
  assign err_overflow = r_err_overflow;
`else
  assign err_dup      = 1'b0;
  assign err_miss     = 1'b0;
  assign err_overflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_r_response_waiting_memory.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_r_response_waiting_memory                                 |
// | Description : Self-checking bench for r_response_waiting_memory. A slot-   |
// |               level reference model predicts each release; predictions are |
// |               queued when the stimulus is driven and popped when the DUT   |
// |               output is sampled. Registered status is compared after each |
// |               edge. Honours R_WM_ERR_CHECK_EN for the expected error flags.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_r_response_waiting_memory;
  import r_rob_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
`ifdef R_WM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  uid_t             wr_uid = '0;
  logic [3:0]       wr_id = '0;
  logic [63:0]      wr_data = '0;
  logic [1:0]       wr_resp = '0;
  logic             wr_last = 1'b0;
  logic [3:0]       wr_tagid = '0;
  logic             rel_en = 1'b0;
  uid_t             rel_uid = '0;
  logic             rel_hit;
  logic [3:0]       rel_id;
  logic [63:0]      rel_data;
  logic [1:0]       rel_resp;
  logic             rel_last;
  logic [3:0]       rel_tagid;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] peak_count;
  logic             err_dup;
  logic             err_miss;
  logic             err_overflow;

  always #5 clk = ~clk;

  r_response_waiting_memory dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_uid       (wr_uid),
    .wr_id        (wr_id),
    .wr_data      (wr_data),
    .wr_resp      (wr_resp),
    .wr_last      (wr_last),
    .wr_tagid     (wr_tagid),
    .rel_en       (rel_en),
    .rel_uid      (rel_uid),
    .rel_hit      (rel_hit),
    .rel_id       (rel_id),
    .rel_data     (rel_data),
    .rel_resp     (rel_resp),
    .rel_last     (rel_last),
    .rel_tagid    (rel_tagid),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .peak_count   (peak_count),
    .err_dup      (err_dup),
    .err_miss     (err_miss),
    .err_overflow (err_overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: slot-level view of the store plus status.
  bit          m_valid [DEPTH];
  uid_t        m_uid   [DEPTH];
  logic [63:0] m_data  [DEPTH];
  int          m_count;
  int          m_peak;
  bit          m_err_dup;
  bit          m_err_miss;
  bit          m_err_ovf;

  typedef struct {
    bit          hit;
    logic [63:0] data;
  } rel_exp_t;

  rel_exp_t exp_q[$];

  // Side fields are derived from the data word so one value checks them all.
  function automatic logic [10:0] side_of(input logic [63:0] d);
    return {d[3:0], d[5:4], d[6], d[11:8]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_count    = 0;
    m_peak     = 0;
    m_err_dup  = 1'b0;
    m_err_miss = 1'b0;
    m_err_ovf  = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, ".count"},    64'(count),        64'(m_count));
    check_eq({tag, ".peak"},     64'(peak_count),   64'(m_peak));
    check_eq({tag, ".full"},     64'(full),         64'(m_count == DEPTH));
    check_eq({tag, ".empty"},    64'(empty),        64'(m_count == 0));
    check_eq({tag, ".err_dup"},  64'(err_dup),      64'(m_err_dup));
    check_eq({tag, ".err_miss"}, 64'(err_miss),     64'(m_err_miss));
    check_eq({tag, ".err_ovf"},  64'(err_overflow), 64'(m_err_ovf));
  endtask

  // One clock cycle of stimulus. Called 1 time unit after a rising edge.
  task automatic step(input string tag, input bit we, input uid_t wu, input logic [63:0] wd,
                      input bit re, input uid_t ru);
    rel_exp_t e;
    rel_exp_t got_e;
    int       hit_i;
    int       free_i;
    bit       dup;
    bit       acc;

    wr_en    = we;
    wr_uid   = wu;
    wr_data  = wd;
    wr_id    = wd[3:0];
    wr_resp  = wd[5:4];
    wr_last  = wd[6];
    wr_tagid = wd[11:8];
    rel_en   = re;
    rel_uid  = ru;

    // Predict the combinational release from pre-edge state.
    hit_i = -1;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (re && m_valid[i] && m_uid[i] == ru) hit_i = i;
    e.hit  = (hit_i >= 0);
    e.data = e.hit ? m_data[hit_i] : 64'h0;
    exp_q.push_back(e);

    #2;
    got_e = exp_q.pop_front();
    check_eq({tag, ".rel_hit"},  64'(rel_hit),  64'(got_e.hit));
    check_eq({tag, ".rel_data"}, rel_data,      got_e.data);
    check_eq({tag, ".rel_side"}, 64'({rel_id, rel_resp, rel_last, rel_tagid}),
             64'(got_e.hit ? side_of(got_e.data) : 11'h0));

    // Advance the model across the edge.
    dup = 1'b0;
    if (ERR_EN)
      for (int i = 0; i < DEPTH; i++)
        if (m_valid[i] && m_uid[i] == wu) dup = 1'b1;
    free_i = -1;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!m_valid[i]) free_i = i;
    if (ERR_EN) begin
      if (we && dup) m_err_dup = 1'b1;
      if (re && hit_i < 0) m_err_miss = 1'b1;
      if (we && m_count == DEPTH) m_err_ovf = 1'b1;
    end
    acc = we && (m_count != DEPTH) && !dup;
    if (hit_i >= 0) begin
      m_valid[hit_i] = 1'b0;
      m_count--;
    end
    if (acc) begin
      m_valid[free_i] = 1'b1;
      m_uid[free_i]   = wu;
      m_data[free_i]  = wd;
      m_count++;
    end
    if (m_count > m_peak) m_peak = m_count;

    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    rel_en = 1'b0;
    check_status(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, released after the next edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_status(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_status("reset");
    check_eq("reset.rel_hit",  64'(rel_hit), 64'h0);
    check_eq("reset.rel_data", rel_data,     64'h0);
    rst = 1'b0;

    // Fill all entries, one write per cycle.
    for (int i = 0; i < DEPTH; i++)
      step("fill", 1'b1, uid_t'(i), 64'hA000_0000_0000_1000 + 64'(i * 16'h0153), 1'b0, '0);

    // Write while full plus a release of a stored entry.
    step("full_wr_rel", 1'b1, 8'h30, 64'h3030, 1'b1, 8'h03);
    // The freed slot is usable on the next cycle.
    step("refill", 1'b1, 8'h31, 64'h3131_0000_0000_0077, 1'b0, '0);

    // Drain everything in a scrambled order, including 0x03 which is gone.
    for (int i = 0; i < DEPTH; i++)
      step("drain", 1'b0, '0, '0, 1'b1, uid_t'((i * 7) % DEPTH));
    step("drain31", 1'b0, '0, '0, 1'b1, 8'h31);

    // Out-of-order release.
    step("ooo_w12", 1'b1, 8'h12, 64'hAA, 1'b0, '0);
    step("ooo_w10", 1'b1, 8'h10, 64'hBB, 1'b0, '0);
    step("ooo_r10", 1'b0, '0, '0, 1'b1, 8'h10);
    step("ooo_r10b", 1'b0, '0, '0, 1'b1, 8'h10);
    step("ooo_r12", 1'b0, '0, '0, 1'b1, 8'h12);

    // Duplicate UID writes.
    step("dup_w1", 1'b1, 8'h21, 64'h0000_2100_0000_0155, 1'b0, '0);
    step("dup_w2", 1'b1, 8'h21, 64'h0000_2200_0000_02AA, 1'b0, '0);
    step("dup_r1", 1'b0, '0, '0, 1'b1, 8'h21);
    step("dup_r2", 1'b0, '0, '0, 1'b1, 8'h21);

    // Same-cycle visibility: no forwarding of a write into the release path.
    step("vis_wr", 1'b1, 8'h05, 64'h0505, 1'b1, 8'h05);
    step("vis_rel", 1'b0, '0, '0, 1'b1, 8'h05);

    // Random mix over a small UID pool.
    for (int i = 0; i < 60; i++)
      step("rand", 1'($urandom_range(0, 1)), uid_t'(8'h40 + $urandom_range(0, 7)),
           {32'($urandom), 32'($urandom)}, 1'($urandom_range(0, 1)),
           uid_t'(8'h40 + $urandom_range(0, 7)));
    for (int i = 0; i < 8; i++)
      step("rand_drain", 1'b0, '0, '0, 1'b1, uid_t'(8'h40 + i));

    // Reset with three entries stored.
    step("rst_w1", 1'b1, 8'h51, 64'h51, 1'b0, '0);
    step("rst_w2", 1'b1, 8'h52, 64'h52, 1'b0, '0);
    step("rst_w3", 1'b1, 8'h53, 64'h53, 1'b0, '0);
    async_reset("midrst");
    step("post_r51", 1'b0, '0, '0, 1'b1, 8'h51);
    step("post_r52", 1'b0, '0, '0, 1'b1, 8'h52);
    step("post_r53", 1'b0, '0, '0, 1'b1, 8'h53);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
